// File: rtl/peak_bin_finder_pkg.sv
// peak_bin_finder_pkg
// Shared definitions for the peak bin finder and the colour-determination stage:
//   - scan FSM state encoding
//   - index width helper and default frame/magnitude parameters
//   - colour band thresholds (1/3 and 2/3 of the bin range) and a band decoder
package peak_bin_finder_pkg;

  localparam int DEFAULT_SAMPLES     = 32;
  localparam int DEFAULT_MAG_W       = 16;
  localparam int DEFAULT_NOISE_FLOOR = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } pbfState_e;

  function automatic int idxWidth(input int samples);
    return (samples > 1) ? $clog2(samples) : 1;
  endfunction

  // Bin boundaries shared with the colour stage: band 0 below LO,
  // band 1 from LO up to HI, band 2 from HI upward.
  localparam int COLOUR_LO_BIN = DEFAULT_SAMPLES / 3;
  localparam int COLOUR_HI_BIN = (2 * DEFAULT_SAMPLES) / 3;

  function automatic logic [1:0] colourBand(input int idx);
    if (idx < COLOUR_LO_BIN)      return 2'd0;
    else if (idx < COLOUR_HI_BIN) return 2'd1;
    else                          return 2'd2;
  endfunction

endpackage

// File: rtl/peak_bin_finder_if.sv
// peak_bin_finder_if
// Bundles the frame control, magnitude stream and result signals of the
// peak bin finder.
//   slave  : the finder (receives start/mag stream, drives ready and results)
//   master : the producer/consumer side
// Ports carried: start, mag_valid, mag_data, mag_ready, index_holder,
//                peak_mag, done, whichRAM, busy.
interface peak_bin_finder_if
  import peak_bin_finder_pkg::*;
#(
  parameter int SAMPLES = DEFAULT_SAMPLES,
  parameter int MAG_W   = DEFAULT_MAG_W
);
  localparam int IDX_W = idxWidth(SAMPLES);

  logic             start;
  logic             mag_valid;
  logic [MAG_W-1:0] mag_data;
  logic             mag_ready;
  logic [IDX_W-1:0] index_holder;
  logic [MAG_W-1:0] peak_mag;
  logic             done;
  logic             whichRAM;
  logic             busy;

  modport slave (
    input  start, mag_valid, mag_data,
    output mag_ready, index_holder, peak_mag, done, whichRAM, busy
  );

  modport master (
    output start, mag_valid, mag_data,
    input  mag_ready, index_holder, peak_mag, done, whichRAM, busy
  );

endinterface

// File: rtl/peak_bin_finder_max_tracker.sv
// max_tracker
// Holds the working maximum magnitude and its bin index for one frame scan.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   clear                   zero the working registers (frame start/abort)
//   load_first              next valid candidate loads unconditionally
//   cand_valid              a qualifying beat is offered this cycle
//   cand_mag, cand_idx      candidate magnitude and its bin index
//   nextMag, nextIdx        working max/index including this cycle's candidate
module max_tracker #(
  parameter int MAG_W = 16,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load_first,
  input  logic             cand_valid,
  input  logic [MAG_W-1:0] cand_mag,
  input  logic [IDX_W-1:0] cand_idx,
  output logic [MAG_W-1:0] nextMag,
  output logic [IDX_W-1:0] nextIdx
);

  logic [MAG_W-1:0] maxMag;
  logic [IDX_W-1:0] maxIdx;
  logic             takeCand;

  // Strict greater-than: on a tie the earlier (lower) bin is kept.
  assign takeCand = cand_valid && (load_first || (cand_mag > maxMag));
  assign nextMag  = takeCand ? cand_mag : maxMag;
  assign nextIdx  = takeCand ? cand_idx : maxIdx;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      maxMag <= '0;
      maxIdx <= '0;
    end else begin
      maxMag <= nextMag;
      maxIdx <= nextIdx;
    end
  end

endmodule

// File: rtl/peak_bin_finder.sv
// peak_bin_finder
// Scans one frame of SAMPLES spectrum magnitudes (bin order 0..SAMPLES-1)
// and reports the bin with the largest magnitude to the colour stage.
// whichRAM toggles per completed frame to keep the ping-pong buffers aligned.
// Ports:
//   clk, reset_n    clock, synchronous active-low reset
//   bus (slave)     start, mag_valid, mag_data in;
//                   mag_ready, index_holder, peak_mag, done, whichRAM, busy out
// Build option: NOISE_GATE_EN -- beats below NOISE_FLOOR are ignored; a
// frame with no qualifying beat reports bin 0 with magnitude 0.
//
// state | meaning
// IDLE  | waiting for start after reset
// SCAN  | accepting beats, tracking the running maximum
// DONE  | result valid and held until the next start
module peak_bin_finder
  import peak_bin_finder_pkg::*;
#(
  parameter int SAMPLES     = DEFAULT_SAMPLES,
  parameter int MAG_W       = DEFAULT_MAG_W,
  parameter int NOISE_FLOOR = DEFAULT_NOISE_FLOOR
) (
  input logic              clk,
  input logic              reset_n,
  peak_bin_finder_if.slave bus
);

  localparam int IDX_W = idxWidth(SAMPLES);
  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(SAMPLES - 1);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] SCAN = ST_SCAN;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]       state;
  logic [IDX_W-1:0] beatCnt;
  logic             haveFirst;
  logic [IDX_W-1:0] indexReg;
  logic [MAG_W-1:0] peakReg;
  logic             doneReg;
  logic             whichReg;

  logic             inScan;
  logic             accept;
  logic             qualify;
  logic             clearWork;
  logic             candValid;
  logic [MAG_W-1:0] nextMag;
  logic [IDX_W-1:0] nextIdx;

  assign inScan = (state == SCAN);

`ifdef NOISE_GATE_EN
  assign qualify = (bus.mag_data >= MAG_W'(NOISE_FLOOR));
`else
  assign qualify = 1'b1;
`endif

  // A start in any state clears the working registers; a beat arriving with
  // an aborting start is dropped.
  assign accept    = inScan && bus.mag_valid && !bus.start;
  assign clearWork = bus.start;
  assign candValid = accept && qualify;

  max_tracker #(
    .MAG_W(MAG_W),
    .IDX_W(IDX_W)
  ) u_maxTracker (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clearWork),
    .load_first(!haveFirst),
    .cand_valid(candValid),
    .cand_mag  (bus.mag_data),
    .cand_idx  (beatCnt),
    .nextMag   (nextMag),
    .nextIdx   (nextIdx)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      beatCnt   <= '0;
      haveFirst <= 1'b0;
      indexReg  <= '0;
      peakReg   <= '0;
      doneReg   <= 1'b0;
      whichReg  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= SCAN;
            doneReg   <= 1'b0;
            beatCnt   <= '0;
            haveFirst <= 1'b0;
          end
        end
        SCAN: begin
          if (bus.start) begin
            beatCnt   <= '0;
            haveFirst <= 1'b0;
          end else if (accept) begin
            beatCnt <= beatCnt + 1'b1;
            if (qualify) haveFirst <= 1'b1;
            // Counter wraps to 0 on this same edge.
            if (beatCnt == LAST_BIN) begin
              indexReg <= nextIdx;
              peakReg  <= nextMag;
              doneReg  <= 1'b1;
              whichReg <= ~whichReg;
              state    <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mag_ready    = inScan;
  assign bus.busy         = inScan;
  assign bus.index_holder = indexReg;
  assign bus.peak_mag     = peakReg;
  assign bus.done         = doneReg;
  assign bus.whichRAM     = whichReg;

endmodule
